// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and constants for the
// down-counting seconds timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] TENTHS_MAX  = 4'd9;
  localparam int         CLK_DIV_DEF = 5000000;

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: command and display bundle between
// panel/software logic and the countdown timer.
interface countdown_timer_if #(
  parameter int SEC_W = 10
);
  logic             load;
  logic [SEC_W-1:0] load_sec;
  logic             start;
  logic             pause;
  logic [SEC_W-1:0] sec;
  logic [3:0]       tenths;
  logic             running;
  logic             done;
  logic             expire;

  modport master (
    output load, load_sec, start, pause,
    input  sec, tenths, running, done, expire
  );

  modport slave (
    input  load, load_sec, start, pause,
    output sec, tenths, running, done, expire
  );
endinterface

// File: rtl/countdown_tick_gen.sv
// countdown_tick_gen: 0.1 s prescaler; tick marks the last
// cycle of each CLK_DIV period while enabled.
module countdown_tick_gen
  import countdown_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: load/start/pause seconds countdown in 0.1 s
// steps; COUNTDOWN_AUTORELOAD_EN restarts from the last load.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int SEC_W   = 10
) (
  input logic               clk,
  input logic               rst_n,
  countdown_timer_if.slave  bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEC_W-1:0] r_sec;
  logic [SEC_W-1:0] w_sec_nxt;
  logic [SEC_W-1:0] w_dec_sec;
  logic [3:0]       r_ten;
  logic [3:0]       w_ten_nxt;
  logic [3:0]       w_dec_ten;
  logic             r_running;
  logic             r_done;
  logic             r_expire;
  logic             w_expire_nxt;
  logic             w_tick;
  logic             w_en;
  logic             w_clr;
  logic             w_at_zero;
  logic             w_dec_zero;
  logic             w_reload_ok;
  logic [SEC_W-1:0] w_reload_sec;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [SEC_W-1:0] r_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reload <= '0;
    end else if (bus.load) begin
      r_reload <= bus.load_sec;
    end
  end

  assign w_reload_sec = r_reload;
  assign w_reload_ok  = |r_reload;
`else
  assign w_reload_sec = '0;
  assign w_reload_ok  = 1'b0;
`endif

  // Prescaler restarts only on a fresh run, not on resume.
  assign w_en  = (r_state == ST_RUN);
  assign w_clr = bus.load |
                 ((r_state == ST_IDLE) & bus.start);

  countdown_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_en),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  assign w_at_zero = (r_sec == '0) && (r_ten == 4'd0);

  always_comb begin
    w_dec_sec = r_sec;
    w_dec_ten = r_ten;
    if (r_ten != 4'd0) begin
      w_dec_ten = r_ten - 4'd1;
    end else if (r_sec != '0) begin
      w_dec_sec = r_sec - SEC_W'(1);
      w_dec_ten = TENTHS_MAX;
    end
  end

  assign w_dec_zero = (w_dec_sec == '0) &&
                      (w_dec_ten == 4'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_sec_nxt    = r_sec;
    w_ten_nxt    = r_ten;
    w_expire_nxt = 1'b0;
    if (bus.load) begin
      w_state_nxt = ST_IDLE;
      w_sec_nxt   = bus.load_sec;
      w_ten_nxt   = 4'd0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_tick) begin
            w_sec_nxt = w_dec_sec;
            w_ten_nxt = w_dec_ten;
            if (w_dec_zero) begin
              w_expire_nxt = 1'b1;
              if (w_reload_ok) begin
                w_sec_nxt = w_reload_sec;
                w_ten_nxt = 4'd0;
              end else begin
                w_state_nxt = ST_DONE;
              end
            end
          end
          // Expiry outranks a coincident pause.
          if (bus.pause && (w_state_nxt == ST_RUN)) begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (bus.start) begin
            if (w_at_zero) begin
              w_state_nxt  = ST_DONE;
              w_expire_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end
        end
        ST_DONE: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sec     <= '0;
      r_ten     <= 4'd0;
      r_expire  <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sec     <= w_sec_nxt;
      r_ten     <= w_ten_nxt;
      r_expire  <= w_expire_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.sec     = r_sec;
  assign bus.tenths  = r_ten;
  assign bus.running = r_running;
  assign bus.done    = r_done;
  assign bus.expire  = r_expire;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vectors plus a remaining-time
// model (total tenths) checked on every falling edge.
module tb_countdown_timer;
  localparam int CLK_DIV = 4;
  localparam int SEC_W   = 10;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;
`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  countdown_timer_if #(.SEC_W(SEC_W)) bus ();

  countdown_timer #(
    .CLK_DIV (CLK_DIV),
    .SEC_W   (SEC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: remaining time as total tenths, phase counts
  // run cycles toward the next 0.1 s step.
  int m_rem;
  int m_phase;
  int m_mode;
  int m_reload;
  int m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_phase = 0; m_mode = M_IDLE;
      m_reload = 0; m_exp = 0;
    end else begin
      m_exp = 0;
      if (bus.load) begin
        m_mode   = M_IDLE;
        m_rem    = int'(bus.load_sec) * 10;
        m_phase  = 0;
        m_reload = int'(bus.load_sec);
      end else if (m_mode == M_RUN) begin
        m_phase++;
        if (m_phase == CLK_DIV) begin
          m_phase = 0;
          if (m_rem > 0) m_rem--;
          if (m_rem == 0) begin
            m_exp = 1;
            if (AUTO && m_reload != 0)
              m_rem = m_reload * 10;
            else
              m_mode = M_DONE;
          end
        end
        if (m_mode == M_RUN && bus.pause) m_mode = M_PAUSE;
      end else if ((m_mode == M_IDLE || m_mode == M_PAUSE)
                   && bus.start) begin
        if (m_mode == M_IDLE) m_phase = 0;
        if (m_rem == 0) begin
          m_mode = M_DONE;
          m_exp  = 1;
        end else begin
          m_mode = M_RUN;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_sec", int'(bus.sec), m_rem / 10);
    chk("m_tenths", int'(bus.tenths), m_rem % 10);
    chk("m_running", int'(bus.running),
        int'(m_mode == M_RUN));
    chk("m_done", int'(bus.done), int'(m_mode == M_DONE));
    chk("m_expire", int'(bus.expire), m_exp);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit l, input bit s,
                       input bit p, input int v);
    bus.load_sec = SEC_W'(v);
    bus.load  = l;
    bus.start = s;
    bus.pause = p;
    step(1);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic chk_disp(input string nm, input int s,
                          input int t);
    chk({nm, "_sec"}, int'(bus.sec), s);
    chk({nm, "_tenths"}, int'(bus.tenths), t);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.load_sec = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #21;
    chk_disp("rst", 0, 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_expire", int'(bus.expire), 0);
    rst_n = 1'b1;
    step(1);

    // 2.0 s countdown: expiry 80 cycles after start
    pulse(1, 0, 0, 2);
    pulse(0, 1, 0, 0);
    chk("t1_running", int'(bus.running), 1);
    chk_disp("t1_start", 2, 0);
    step(4);
    chk_disp("t1_first", 1, 9);
    step(75);
    chk("t1_exp_early", int'(bus.expire), 0);
    chk_disp("t1_c79", 0, 1);
    step(1);
    chk("t1_expire", int'(bus.expire), 1);
    chk_disp("t1_c80", 0, 0);
    step(1);
    chk("t1_exp_pulse", int'(bus.expire), 0);
    chk("t1_done", int'(bus.done), AUTO ? 0 : 1);
    chk("t1_run_after", int'(bus.running), AUTO ? 1 : 0);

    // pause holds digits and prescaler phase
    pulse(1, 0, 0, 1);
    pulse(0, 1, 0, 0);
    step(5);
    pulse(0, 0, 1, 0);
    chk_disp("t2_paused", 0, 9);
    chk("t2_running", int'(bus.running), 0);
    step(50);
    chk_disp("t2_hold", 0, 9);
    pulse(0, 1, 0, 0);
    chk("t2_resume", int'(bus.running), 1);
    step(1);
    chk_disp("t2_resume1", 0, 9);
    step(1);
    chk_disp("t2_resume2", 0, 8);

    // start at 0.0 expires immediately; start in DONE ignored
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("t3_done", int'(bus.done), 1);
    chk("t3_expire", int'(bus.expire), 1);
    chk("t3_running", int'(bus.running), 0);
    step(1);
    chk("t3_exp_pulse", int'(bus.expire), 0);
    pulse(0, 1, 0, 0);
    chk("t3_start_ign", int'(bus.done), 1);
    chk("t3_no_run", int'(bus.running), 0);
    step(3);
    chk("t3_done_hold", int'(bus.done), 1);

    // load+start on a tick edge: load wins, no decrement
    pulse(1, 0, 0, 5);
    pulse(0, 1, 0, 0);
    step(3);
    chk_disp("t4_before", 5, 0);
    pulse(1, 1, 0, 7);
    chk_disp("t4_reload", 7, 0);
    chk("t4_running", int'(bus.running), 0);
    chk("t4_done", int'(bus.done), 0);
    step(5);
    chk_disp("t4_idle", 7, 0);

    // pause on the tick at 3.0: decrement then freeze
    pulse(1, 0, 0, 3);
    pulse(0, 1, 0, 0);
    step(3);
    pulse(0, 0, 1, 0);
    chk_disp("t5_paused", 2, 9);
    chk("t5_running", int'(bus.running), 0);
    step(10);
    chk_disp("t5_hold", 2, 9);

    // asynchronous reset between edges
    pulse(1, 0, 0, 3);
    pulse(0, 1, 0, 0);
    step(6);
    #2 rst_n = 1'b0;
    #1;
    chk_disp("t6_rst", 0, 0);
    chk("t6_running", int'(bus.running), 0);
    chk("t6_done", int'(bus.done), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("t6_idle", int'(bus.running), 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // auto-reload: 1.0 s period, expire every 40 cycles
    pulse(1, 0, 0, 1);
    pulse(0, 1, 0, 0);
    step(39);
    chk("t7_exp_early", int'(bus.expire), 0);
    step(1);
    chk("t7_expire1", int'(bus.expire), 1);
    chk("t7_running", int'(bus.running), 1);
    chk_disp("t7_reload", 1, 0);
    step(40);
    chk("t7_expire2", int'(bus.expire), 1);
    chk("t7_done", int'(bus.done), 0);
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
